// File: rtl/connection_pkg.sv
// Shared Q-format definitions and saturating arithmetic for the connection bank.
// The helpers work at a fixed wide width so that any W up to 32 bits can share them.
package connection_pkg;

  localparam int Q_INT_BITS  = 8;
  localparam int Q_FRAC_BITS = 8;
  localparam int Q_W         = Q_INT_BITS + Q_FRAC_BITS;
  localparam int Q_ONE       = 1 << Q_FRAC_BITS;
  localparam int QMAX        = 64;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  typedef logic signed [QMAX-1:0] qwide_t;

  function automatic qwide_t clamp(input qwide_t v, input int w);
    qwide_t hi;
    qwide_t lo;
    hi = (qwide_t'(1) <<< (w - 1)) - qwide_t'(1);
    lo = -hi - qwide_t'(1);
    if (v > hi)      clamp = hi;
    else if (v < lo) clamp = lo;
    else             clamp = v;
  endfunction

  // Operands must arrive sign-extended; the wide sum cannot overflow.
  function automatic qwide_t sat_add(input qwide_t a, input qwide_t b, input int w);
    sat_add = clamp(a + b, w);
  endfunction

  // Arithmetic shift truncates toward -inf.
  function automatic qwide_t q_mul_sat(input qwide_t a, input qwide_t b,
                                       input int w, input int fb);
    q_mul_sat = clamp((a * b) >>> fb, w);
  endfunction

endpackage

// File: rtl/conn_update_alu.sv
// Combinational momentum update for one connection:
// delta = sat(sat(eta*grad) + sat(alpha*prev_delta)); weight' = sat(weight + delta).
module conn_update_alu
  import connection_pkg::*;
#(
  parameter int W  = Q_W,
  parameter int FB = Q_FRAC_BITS
) (
  input  logic signed [W-1:0] weight,
  input  logic signed [W-1:0] gradient,
  input  logic signed [W-1:0] prev_delta,
  input  logic signed [W-1:0] eta,
  input  logic signed [W-1:0] alpha,
  output logic signed [W-1:0] new_weight,
  output logic signed [W-1:0] new_delta
);

  qwide_t p1;
  qwide_t p2;
  qwide_t d;

  always_comb begin
    p1         = q_mul_sat(qwide_t'(eta), qwide_t'(gradient), W, FB);
    p2         = q_mul_sat(qwide_t'(alpha), qwide_t'(prev_delta), W, FB);
    d          = sat_add(p1, p2, W);
    new_delta  = W'(d);
    new_weight = W'(sat_add(qwide_t'(weight), d, W));
  end

endmodule

// File: rtl/connection_bank.sv
// Bank of NUM_CONN trainable connections: loads, gradient accumulation and a
// one-connection-per-cycle momentum update sweep, with combinational readback.
module connection_bank
  import connection_pkg::*;
#(
  parameter int FIXED_BITS      = Q_INT_BITS,
  parameter int FRACTIONAL_BITS = Q_FRAC_BITS,
  parameter int NUM_CONN        = 16,
  localparam int W = FIXED_BITS + FRACTIONAL_BITS,
  localparam int A = $clog2(NUM_CONN)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [W-1:0] weight_in,
  input  logic         grad_valid,
  input  logic [A-1:0] grad_addr,
  input  logic [W-1:0] grad_in,
  input  logic         upd_start,
  input  logic [W-1:0] eta,
  input  logic [W-1:0] alpha,
  output logic         ready,
  output logic         busy,
  output logic         upd_done,
  input  logic [A-1:0] rd_addr,
  output logic [W-1:0] rd_weight,
  output logic [W-1:0] rd_delta,
  output logic [W-1:0] rd_grad,
  output logic [W-1:0] rd_prev_delta
);

  logic signed [W-1:0] weight     [NUM_CONN];
  logic signed [W-1:0] delta      [NUM_CONN];
  logic signed [W-1:0] gradient   [NUM_CONN];
  logic signed [W-1:0] prev_delta [NUM_CONN];

  logic signed [W-1:0] eta_q;
  logic signed [W-1:0] alpha_q;
  logic [A-1:0]        index;
  logic signed [W-1:0] new_weight;
  logic signed [W-1:0] new_delta;

  state_t state;
  state_t next_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (upd_start) next_state = SWEEP;
      SWEEP:   if (index == A'(NUM_CONN - 1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready    = (state == IDLE);
    busy     = (state == SWEEP);
    upd_done = (state == DONE);
  end

  conn_update_alu #(.W(W), .FB(FRACTIONAL_BITS)) u_alu (
    .weight     (weight[index]),
    .gradient   (gradient[index]),
    .prev_delta (prev_delta[index]),
    .eta        (eta_q),
    .alpha      (alpha_q),
    .new_weight (new_weight),
    .new_delta  (new_delta)
  );

  // NOTE: the array is in flops, not RAM, because reset must clear every field
  // at once, even mid-sweep; a RAM macro could not be cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CONN; i++) begin
        weight[i]     <= '0;
        delta[i]      <= '0;
        gradient[i]   <= '0;
        prev_delta[i] <= '0;
      end
      eta_q   <= '0;
      alpha_q <= '0;
      index   <= '0;
    end else if (state == IDLE) begin
      // Loads and gradients land at the start edge too, so the sweep sees them.
      if (wr_en)
        weight[wr_addr] <= weight_in;
      if (grad_valid)
        gradient[grad_addr] <= W'(sat_add(qwide_t'(gradient[grad_addr]),
                                          qwide_t'($signed(grad_in)), W));
      if (upd_start) begin
        eta_q   <= eta;
        alpha_q <= alpha;
        index   <= '0;
      end
    end else if (state == SWEEP) begin
      weight[index]     <= new_weight;
      delta[index]      <= new_delta;
      prev_delta[index] <= new_delta;
      gradient[index]   <= '0;
      index             <= index + A'(1);
    end
  end

  assign rd_weight     = weight[rd_addr];
  assign rd_delta      = delta[rd_addr];
  assign rd_grad       = gradient[rd_addr];
  assign rd_prev_delta = prev_delta[rd_addr];

endmodule

// File: tb/tb_connection_bank.sv
// Directed bench for connection_bank at Q8.8, NUM_CONN=4; expected values are
// hand-computed Q8.8 constants.
module tb_connection_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, grad_valid, upd_start;
  logic [1:0]  wr_addr, grad_addr, rd_addr;
  logic [15:0] weight_in, grad_in, eta, alpha;
  logic        ready, busy, upd_done;
  logic [15:0] rd_weight, rd_delta, rd_grad, rd_prev_delta;

  int n_cmp = 0;
  int n_err = 0;

  connection_bank #(.FIXED_BITS(8), .FRACTIONAL_BITS(8), .NUM_CONN(4)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .weight_in(weight_in),
    .grad_valid(grad_valid), .grad_addr(grad_addr), .grad_in(grad_in),
    .upd_start(upd_start), .eta(eta), .alpha(alpha),
    .ready(ready), .busy(busy), .upd_done(upd_done),
    .rd_addr(rd_addr), .rd_weight(rd_weight), .rd_delta(rd_delta),
    .rd_grad(rd_grad), .rd_prev_delta(rd_prev_delta)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    wr_en = 0; grad_valid = 0; upd_start = 0;
    wr_addr = 0; grad_addr = 0; weight_in = 0; grad_in = 0;
  endtask

  task automatic load(input logic [1:0] a, input logic [15:0] v);
    wr_en = 1; wr_addr = a; weight_in = v;
    tick();
    clear_inputs();
  endtask

  task automatic accum(input logic [1:0] a, input logic [15:0] v);
    grad_valid = 1; grad_addr = a; grad_in = v;
    tick();
    clear_inputs();
  endtask

  // Any loads/gradients already driven are presented in the start cycle as well.
  task automatic run_sweep(input logic [15:0] e, input logic [15:0] al,
                           output int busy_n, output int done_n, output int done_at);
    busy_n = 0; done_n = 0; done_at = -1;
    upd_start = 1; eta = e; alpha = al;
    tick();
    clear_inputs();
    for (int c = 0; c < 10; c++) begin
      busy_n += int'(busy);
      if (upd_done) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    if (ready !== 1'b1 || busy !== 1'b0 || upd_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: ready/busy/done got %b%b%b want 100", ready, busy, upd_done);
    end
    n_cmp++;
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      if ({rd_weight, rd_delta, rd_grad, rd_prev_delta} !== 64'h0) begin
        n_err++;
        $display("FAIL reset_fields[%0d]: got %h %h %h %h want all 0000", a,
                 rd_weight, rd_delta, rd_grad, rd_prev_delta);
      end
      n_cmp++;
    end
  endtask

  task automatic test_basic_update;
    int bn, dn, da;
    load(2, 16'h0100);
    accum(2, 16'h0080);
    accum(2, 16'h0080);
    rd_addr = 2; #1;
    if (rd_grad !== 16'h0100) begin
      n_err++; $display("FAIL basic_grad_acc: got %h want 0100", rd_grad);
    end
    n_cmp++;
    run_sweep(16'h0080, 16'h0000, bn, dn, da);
    if (bn !== 4 || dn !== 1 || da !== 4) begin
      n_err++;
      $display("FAIL basic_latency: busy=%0d done=%0d at=%0d want 4 1 4", bn, dn, da);
    end
    n_cmp++;
    rd_addr = 2; #1;
    if (rd_weight !== 16'h0180 || rd_delta !== 16'h0080 ||
        rd_prev_delta !== 16'h0080 || rd_grad !== 16'h0000) begin
      n_err++;
      $display("FAIL basic_fields: got w=%h d=%h pd=%h g=%h want 0180 0080 0080 0000",
               rd_weight, rd_delta, rd_prev_delta, rd_grad);
    end
    n_cmp++;
    rd_addr = 1; #1;
    if (rd_weight !== 16'h0000 || rd_delta !== 16'h0000) begin
      n_err++; $display("FAIL basic_other: got w=%h d=%h want 0000 0000", rd_weight, rd_delta);
    end
    n_cmp++;
  endtask

  task automatic test_momentum;
    int bn, dn, da;
    run_sweep(16'h0080, 16'h0080, bn, dn, da);
    rd_addr = 2; #1;
    if (rd_weight !== 16'h01C0 || rd_delta !== 16'h0040 || rd_prev_delta !== 16'h0040) begin
      n_err++;
      $display("FAIL momentum: got w=%h d=%h pd=%h want 01c0 0040 0040",
               rd_weight, rd_delta, rd_prev_delta);
    end
    n_cmp++;
    if (dn !== 1) begin
      n_err++; $display("FAIL momentum_done: got %0d pulses want 1", dn);
    end
    n_cmp++;
  endtask

  task automatic test_saturation;
    int bn, dn, da;
    load(0, 16'h7F00);
    accum(0, 16'h7FFF);
    run_sweep(16'h0100, 16'h0000, bn, dn, da);
    rd_addr = 0; #1;
    if (rd_delta !== 16'h7FFF || rd_weight !== 16'h7FFF) begin
      n_err++; $display("FAIL sat_pos: got d=%h w=%h want 7fff 7fff", rd_delta, rd_weight);
    end
    n_cmp++;
    load(0, 16'h8100);
    accum(0, 16'h8000);
    run_sweep(16'h0100, 16'h0000, bn, dn, da);
    rd_addr = 0; #1;
    if (rd_delta !== 16'h8000 || rd_weight !== 16'h8000) begin
      n_err++; $display("FAIL sat_neg: got d=%h w=%h want 8000 8000", rd_delta, rd_weight);
    end
    n_cmp++;
    rd_addr = 2; #1;
    if (rd_weight !== 16'h01C0 || rd_delta !== 16'h0000) begin
      n_err++; $display("FAIL sat_other: got w=%h d=%h want 01c0 0000", rd_weight, rd_delta);
    end
    n_cmp++;
  endtask

  task automatic test_grad_clamp_and_ignore;
    bit seen;
    accum(1, 16'h7000);
    accum(1, 16'h7000);
    rd_addr = 1; #1;
    if (rd_grad !== 16'h7FFF) begin
      n_err++; $display("FAIL grad_clamp: got %h want 7fff", rd_grad);
    end
    n_cmp++;
    upd_start = 1; eta = 16'h0000; alpha = 16'h0000;
    tick();
    wr_en = 1; wr_addr = 3; weight_in = 16'h1234;
    grad_valid = 1; grad_addr = 3; grad_in = 16'h0100;
    tick(); tick();
    clear_inputs();
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      if (upd_done) seen = 1;
      tick();
    end
    if (!seen) begin
      n_err++; $display("FAIL ignore_done: got no upd_done want pulse");
    end
    n_cmp++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL ignore_idle: got ready=%b busy=%b want 1 0", ready, busy);
    end
    n_cmp++;
    rd_addr = 3; #1;
    if (rd_weight !== 16'h0000 || rd_grad !== 16'h0000) begin
      n_err++; $display("FAIL ignore_writes: got w=%h g=%h want 0000 0000", rd_weight, rd_grad);
    end
    n_cmp++;
    rd_addr = 1; #1;
    if (rd_grad !== 16'h0000 || rd_weight !== 16'h0000) begin
      n_err++; $display("FAIL ignore_clear: got g=%h w=%h want 0000 0000", rd_grad, rd_weight);
    end
    n_cmp++;
    rd_addr = 0; #1;
    if (rd_weight !== 16'h8000 || rd_delta !== 16'h0000) begin
      n_err++; $display("FAIL zero_eta: got w=%h d=%h want 8000 0000", rd_weight, rd_delta);
    end
    n_cmp++;
  endtask

  task automatic test_mid_sweep_reset;
    int bn, dn, da, pulses;
    load(1, 16'h0200);
    accum(1, 16'h0100);
    upd_start = 1; eta = 16'h0100; alpha = 16'h0000;
    tick();
    clear_inputs();
    tick();
    rst = 1; #1;
    if (busy !== 1'b0 || ready !== 1'b1 || upd_done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_flags: ready/busy/done got %b%b%b want 100", ready, busy, upd_done);
    end
    n_cmp++;
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      if ({rd_weight, rd_delta, rd_grad, rd_prev_delta} !== 64'h0) begin
        n_err++;
        $display("FAIL rst_fields[%0d]: got %h %h %h %h want all 0000", a,
                 rd_weight, rd_delta, rd_grad, rd_prev_delta);
      end
      n_cmp++;
    end
    tick();
    rst = 0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      pulses += int'(upd_done);
      tick();
    end
    if (pulses !== 0) begin
      n_err++; $display("FAIL rst_no_done: got %0d pulses want 0", pulses);
    end
    n_cmp++;
    // Load, gradient and start in one cycle: the sweep must use the new values.
    wr_en = 1; wr_addr = 3; weight_in = 16'h0100;
    grad_valid = 1; grad_addr = 3; grad_in = 16'h0100;
    run_sweep(connection_pkg::Q_ONE[15:0], 16'h0000, bn, dn, da);
    if (bn !== 4 || dn !== 1 || da !== 4) begin
      n_err++;
      $display("FAIL fresh_latency: busy=%0d done=%0d at=%0d want 4 1 4", bn, dn, da);
    end
    n_cmp++;
    rd_addr = 3; #1;
    if (rd_weight !== 16'h0200 || rd_delta !== 16'h0100 || rd_grad !== 16'h0000) begin
      n_err++;
      $display("FAIL fresh_fields: got w=%h d=%h g=%h want 0200 0100 0000",
               rd_weight, rd_delta, rd_grad);
    end
    n_cmp++;
  endtask

  initial begin
    rst = 1; rd_addr = 0; eta = 0; alpha = 0;
    clear_inputs();
    tick(); tick();
    rst = 0;
    tick();
    test_reset();
    test_basic_update();
    test_momentum();
    test_saturation();
    test_grad_clamp_and_ignore();
    test_mid_sweep_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/connection_bank.md
Name: connection_bank

Overview:
- Parametrised, trainable successor to the single-connection weight holder.
- Stores NUM_CONN connections in Q-format. Each connection has four fields: weight, delta_weight, gradient, prev_delta_weight.
- Accumulates per-connection gradients and applies a sequential momentum update: delta = eta*gradient + alpha*prev_delta; weight += delta.
- Sits between the neuron datapath (gradient producer, weight consumer) and the training controller (issues update sweeps).

Parameters:
- FIXED_BITS, 8, integer bits of the Q-format word (sign included).
- FRACTIONAL_BITS, 8, fractional bits. Word width W = FIXED_BITS+FRACTIONAL_BITS.
- NUM_CONN, 16, number of connections, >= 2. Address width A = $clog2(NUM_CONN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  load weight_in into weight[wr_addr].
- wr_addr  in  A  load address.
- weight_in  in  W  signed Q weight to load.
- grad_valid  in  1  accumulate grad_in into gradient[grad_addr].
- grad_addr  in  A  gradient address.
- grad_in  in  W  signed Q gradient contribution.
- upd_start  in  1  request one momentum update sweep over all connections.
- eta  in  W  signed Q learning rate. Sampled at upd_start acceptance.
- alpha  in  W  signed Q momentum. Sampled at upd_start acceptance.
- ready  out  1  high in IDLE; loads, gradients and starts are accepted only when ready=1.
- busy  out  1  high while sweeping.
- upd_done  out  1  one-cycle pulse at sweep end.
- rd_addr  in  A  read address.
- rd_weight, rd_delta, rd_grad, rd_prev_delta  out  W each  combinational read of the four fields at rd_addr.

Behaviour:
- Reset (async, any state, including mid-sweep):
  - All four fields of every connection = 0.
  - FSM = IDLE; ready=1, busy=0, upd_done=0.
  - Latched eta/alpha = 0; sweep index = 0.
- FSM states: IDLE -> SWEEP -> DONE -> IDLE.
- IDLE:
  - wr_en: weight[wr_addr] <= weight_in at the next edge.
  - grad_valid: gradient[grad_addr] <= sat(gradient + grad_in).
  - wr_en and grad_valid may target the same address in the same cycle; both take effect (different fields).
  - upd_start: latch eta/alpha, index <= 0, go to SWEEP. Loads and gradients presented in that same cycle are still applied.
  - Precedence on simultaneous upd_start + wr_en/grad_valid: load/accumulate first, then the sweep uses the updated values.
- SWEEP: processes connection i = index, one connection per cycle, over NUM_CONN cycles. For connection i:
  - p1 = sat(trunc(eta*gradient[i]))
  - p2 = sat(trunc(alpha*prev_delta[i]))
  - d = sat(p1 + p2)
  - Writes: weight[i] <= sat(weight[i] + d); delta_weight[i] <= d; prev_delta_weight[i] <= d; gradient[i] <= 0.
  - index wraps: after NUM_CONN-1, go to DONE.
  - wr_en, grad_valid and upd_start are ignored while SWEEP (ready=0). This is not an error.
- DONE: upd_done=1 for exactly one cycle, busy=0, then IDLE (ready=1 again in the following cycle).
- Latency: start accepted at edge k; busy high for cycles k+1 .. k+NUM_CONN; upd_done high in cycle k+NUM_CONN+1.
- Arithmetic:
  - Products are 2W-bit signed, arithmetically shifted right by FRACTIONAL_BITS (truncation toward -inf).
  - sat() clamps to [-2^(W-1), 2^(W-1)-1]. Sums are computed at W+1 bits before clamping.
- Reads are combinational from the register array. During SWEEP they reflect values already committed at prior edges.

Decomposition:
- Shared package connection_pkg:
  - Q-format width localparams.
  - sat_add function (W+1 -> W).
  - q_mul_sat function (2W product, shift, clamp).
  - Q_ONE constant = 1<<FRACTIONAL_BITS.
- One sub-module: conn_update_alu. Combinational: weight, gradient, prev_delta, eta, alpha -> new_weight, new_delta. Unit-testable on its own.

Test Plan (Q8.8, W=16, NUM_CONN=4):
- Reset then read every address -> all four fields 0x0000; ready=1, busy=0.
- Load weight[2]=0x0100; grad_valid grad_in=0x0080 twice at addr 2; upd_start with eta=0x0080, alpha=0 -> busy 4 cycles, upd_done pulse in cycle 5; weight[2]=0x0180, delta=prev_delta=0x0080, grad=0.
- Then upd_start with eta=0x0080, alpha=0x0080, no gradients -> weight[2]=0x01C0, delta=0x0040.
- Saturation: weight[0]=0x7F00, grad 0x7FFF, eta=0x0100, alpha=0 -> delta[0]=0x7FFF, weight[0]=0x7FFF. Negative mirror: weight=0x8100, grad 0x8000 -> weight[0]=0x8000.
- Gradient accumulation clamp: grad_in=0x7000 twice -> gradient=0x7FFF. A wr_en/grad_valid issued during SWEEP changes nothing.
- Assert rst in the 2nd SWEEP cycle -> all fields 0 immediately, busy=0, no upd_done pulse; a fresh upd_start afterwards completes normally.
